// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame edge counts and default timing for the PS/2 host transmitter
package ps2_pkg;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] INHIBIT   = 3'd1;
   localparam logic [2:0] REQ       = 3'd2;
   localparam logic [2:0] SHIFT     = 3'd3;
   localparam logic [2:0] ACK       = 3'd4;
   localparam logic [2:0] WAIT_IDLE = 3'd5;

   localparam logic [3:0] STOP_EDGE = 4'd10;
   localparam logic [3:0] ACK_EDGE  = 4'd11;

   localparam int DEF_INHIBIT_CYCLES = 10000;
   localparam int DEF_TIMEOUT_CYCLES = 1500000;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: two-flop synchronizer for one PS/2 line with falling-edge detect on the synchronized level
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic line_i,
   output logic level_o,
   output logic fall_o
);

   logic [2:0] sync_q;

   // two sync stages plus one history stage; an idle PS/2 line is high
   always_ff @(posedge clk or negedge reset)
      if (!reset) sync_q <= 3'b111;
      else sync_q <= {sync_q[1:0], line_i};

   assign level_o = sync_q[1];
   assign fall_o  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-bit frame, ack check).
// Define PS2_TX_TIMEOUT_EN to add a device-clock watchdog that aborts a stalled frame with tx_error.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_drive_low,
   output logic       ps2_data_drive_low
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);

   logic          clk_s, clk_fall, data_s, data_fall_unused;
   logic [2:0]    state_q, state_d;
   logic [IW-1:0] inh_q, inh_d;
   logic [3:0]    edge_q, edge_d;
   logic [8:0]    shift_q, shift_d;
   logic          clk_low_q, clk_low_d, data_low_q, data_low_d;
   logic          done_q, done_d, error_q, error_d;

   ps2_sync_edge u_clk_sync (.clk(clk), .reset(reset), .line_i(ps2_clk_i), .level_o(clk_s), .fall_o(clk_fall));
   ps2_sync_edge u_data_sync (.clk(clk), .reset(reset), .line_i(ps2_data_i), .level_o(data_s), .fall_o(data_fall_unused));

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd_q, wd_d;
   logic          watched;

   assign watched = (state_q == REQ) || (state_q == SHIFT) || (state_q == ACK);

   // watchdog restarts on every device clock edge and outside the device-clocked states
   always_ff @(posedge clk or negedge reset)
      if (!reset) wd_q <= '0;
      else wd_q <= wd_d;
`endif

   // frame sequencing; the shift register holds {parity, data} and fills with ones so the stop bit releases data
   always_comb begin
      state_d    = state_q;
      inh_d      = inh_q;
      edge_d     = edge_q;
      shift_d    = shift_q;
      clk_low_d  = clk_low_q;
      data_low_d = data_low_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      case (state_q)
         IDLE: if (tx_valid) begin
            state_d    = INHIBIT;
            shift_d    = {odd_parity(tx_data), tx_data};
            inh_d      = '0;
            edge_d     = '0;
            clk_low_d  = 1'b1;
            data_low_d = 1'b0;
         end
         INHIBIT: begin
            inh_d = inh_q + 1'b1;
            if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
               state_d    = REQ;
               data_low_d = 1'b1;
            end
         end
         REQ: begin
            clk_low_d = 1'b0;
            state_d   = SHIFT;
         end
         SHIFT: if (clk_fall) begin
            edge_d     = edge_q + 1'b1;
            data_low_d = ~shift_q[0];
            shift_d    = {1'b1, shift_q[8:1]};
            state_d    = (edge_q == STOP_EDGE - 4'd1) ? ACK : SHIFT;
         end
         ACK: if (clk_fall) begin
            edge_d  = ACK_EDGE;
            state_d = data_s ? IDLE : WAIT_IDLE;
            error_d = data_s;
         end
         WAIT_IDLE: if (clk_s && data_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      wd_d = (watched && !clk_fall) ? wd_q + 1'b1 : '0;
      if (watched && !clk_fall && wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
         state_d    = IDLE;
         clk_low_d  = 1'b0;
         data_low_d = 1'b0;
         error_d    = 1'b1;
         wd_d       = '0;
      end
`endif
   end

   // state and line-drive registers; reset releases both lines at once
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q    <= IDLE;
         inh_q      <= '0;
         edge_q     <= '0;
         shift_q    <= '0;
         clk_low_q  <= 1'b0;
         data_low_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         inh_q      <= inh_d;
         edge_q     <= edge_d;
         shift_q    <= shift_d;
         clk_low_q  <= clk_low_d;
         data_low_q <= data_low_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end

   assign tx_ready           = state_q == IDLE;
   assign tx_done            = done_q;
   assign tx_error           = error_q;
   assign ps2_clk_drive_low  = clk_low_q;
   assign ps2_data_drive_low = data_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model for ps2_host_tx
module tb_ps2_host_tx;

   localparam int H  = 20;
   localparam int TO = 2000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_error;
   logic       ps2_clk_drive_low, ps2_data_drive_low;
   logic       ps2_clk_i, ps2_data_i;
   logic       dev_clk = 1'b1, dev_data = 1'b1;
   int         n_chk = 0, n_fail = 0;
   int         done_cnt = 0, err_cnt = 0, inh_cnt = 0;

   assign ps2_clk_i  = dev_clk & ~ps2_clk_drive_low;
   assign ps2_data_i = dev_data & ~ps2_data_drive_low;

   always #5 clk = ~clk;

   ps2_host_tx #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error),
      .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
      .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low)
   );

   always @(negedge clk) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (ps2_clk_drive_low && !ps2_data_drive_low) inh_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      while (!tx_ready && t < 50000) begin
         @(negedge clk);
         t++;
      end
      check("ready_before_send", {31'd0, tx_ready}, 32'd1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic dev_frame(input int n_edges, input bit ack, output logic [9:0] bits, output bit ok);
      int t = 0;
      bits = '1;
      ok   = 1'b0;
      while (!(ps2_data_drive_low && !ps2_clk_drive_low) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) return;
      ok = 1'b1;
      repeat (H) @(negedge clk);
      for (int e = 1; e <= n_edges; e++) begin
         if (e == 11) dev_data = ack ? 1'b0 : 1'b1;
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         if (e <= 10) bits[e-1] = ps2_data_i;
         dev_clk = 1'b1;
         repeat (H) @(negedge clk);
      end
      dev_data = 1'b1;
   endtask

   initial begin
      logic [9:0] frame;
      bit         ok;
      int         d0, e0, i0, t;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_clk_drv", {31'd0, ps2_clk_drive_low}, 32'd0);
      check("rst_data_drv", {31'd0, ps2_data_drive_low}, 32'd0);
      check("rst_done_err", {30'd0, tx_done, tx_error}, 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // 0xF4 with ack: bits 0,0,1,0,1,1,1,1, parity 0, stop 1
      d0 = done_cnt; e0 = err_cnt;
      send(8'hF4);
      dev_frame(11, 1'b1, frame, ok);
      repeat (20) @(negedge clk);
      check("f4_rts", {31'd0, ok}, 32'd1);
      check("f4_frame", {22'd0, frame}, 32'h2F4);
      check("f4_done", done_cnt - d0, 32'd1);
      check("f4_err", err_cnt - e0, 32'd0);

      // 0xFF: parity 1, inhibit exactly 10000 cycles
      d0 = done_cnt; i0 = inh_cnt;
      send(8'hFF);
      dev_frame(11, 1'b1, frame, ok);
      repeat (20) @(negedge clk);
      check("ff_frame", {22'd0, frame}, 32'h3FF);
      check("ff_inhibit", inh_cnt - i0, 32'd10000);
      check("ff_done", done_cnt - d0, 32'd1);

      // 0x01 without ack: parity 0, one error, no done
      d0 = done_cnt; e0 = err_cnt;
      send(8'h01);
      dev_frame(11, 1'b0, frame, ok);
      repeat (20) @(negedge clk);
      check("nack_frame", {22'd0, frame}, 32'h201);
      check("nack_err", err_cnt - e0, 32'd1);
      check("nack_done", done_cnt - d0, 32'd0);
      check("nack_ready", {31'd0, tx_ready}, 32'd1);

`ifdef PS2_TX_TIMEOUT_EN
      // device stops after edge 4; error ~TO cycles later plus synchronizer latency
      d0 = done_cnt; e0 = err_cnt;
      send(8'h12);
      dev_frame(4, 1'b1, frame, ok);
      t = 2 * H;
      while (err_cnt == e0 && t < TO + 100) begin
         @(negedge clk);
         t++;
      end
      check("to_latency_ok", {31'd0, (t >= TO && t <= TO + 6)}, 32'd1);
      check("to_err", err_cnt - e0, 32'd1);
      check("to_lines", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd0);
      repeat (5) @(negedge clk);
      check("to_ready", {31'd0, tx_ready}, 32'd1);
      check("to_done", done_cnt - d0, 32'd0);
`endif

      // reset after edge 5 of 0x0C (bit 4 = 0 so data is driven low)
      d0 = done_cnt; e0 = err_cnt;
      send(8'h0C);
      dev_frame(5, 1'b1, frame, ok);
      check("abort_pre_data", {31'd0, ps2_data_drive_low}, 32'd1);
      check("abort_pre_ready", {31'd0, tx_ready}, 32'd0);
      reset = 1'b0;
      #1;
      check("abort_lines", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd0);
      check("abort_ready", {31'd0, tx_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);

      // 0xED after abort completes normally
      d0 = done_cnt;
      send(8'hED);
      dev_frame(11, 1'b1, frame, ok);
      repeat (20) @(negedge clk);
      check("ed_frame", {22'd0, frame}, 32'h3ED);
      check("ed_done", done_cnt - d0, 32'd1);

      // 0xAA offered while 0x55 is busy must be ignored
      d0 = done_cnt;
      send(8'h55);
      repeat (5) @(negedge clk);
      check("busy_ready", {31'd0, tx_ready}, 32'd0);
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
      repeat (50) @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      dev_frame(11, 1'b1, frame, ok);
      repeat (20) @(negedge clk);
      check("busy_frame", {22'd0, frame}, 32'h355);
      check("busy_done", done_cnt - d0, 32'd1);
      repeat (30) @(negedge clk);
      check("busy_no_second", {31'd0, ps2_clk_drive_low}, 32'd0);
      check("busy_idle_ready", {31'd0, tx_ready}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
